// File: rtl/dma_model_pkg.sv
// Shared definitions for the 8237-style DMA programming-interface model:
// register address map and the classification of a sampled CPU bus cycle.
package dma_model_pkg;

    // Command/control register addresses (A3..A0)
    localparam logic [3:0] ADDR_CMD     = 4'h8;
    localparam logic [3:0] ADDR_REQ     = 4'h9;
    localparam logic [3:0] ADDR_SMASK   = 4'hA;
    localparam logic [3:0] ADDR_MODE    = 4'hB;
    localparam logic [3:0] ADDR_CLRFF   = 4'hC;
    localparam logic [3:0] ADDR_MCLR    = 4'hD;
    localparam logic [3:0] ADDR_CLRMASK = 4'hE;
    localparam logic [3:0] ADDR_ALLMASK = 4'hF;

    // Read-side aliases of the same address slots
    localparam logic [3:0] ADDR_STATUS  = 4'h8;
    localparam logic [3:0] ADDR_TEMP    = 4'hD;

    // What the CPU bus is doing in one sampled cycle
    typedef enum logic [1:0] {
        ACC_NONE     = 2'd0,  // not selected, or no strobe low
        ACC_WRITE    = 2'd1,  // selected, IOW_N low only
        ACC_READ     = 2'd2,  // selected, IOR_N low only
        ACC_CONFLICT = 2'd3   // selected, both strobes low
    } access_kind_e;

endpackage

// File: rtl/dma_access_edge.sv
// Bus-cycle qualification and first-cycle detection for the DMA register
// model. Classifies each sampled cycle and flags the first cycle of every
// write, read or conflicting episode by comparing against the previous
// cycle's classification.
module dma_access_edge
    import dma_model_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_program_condition,
    input  logic         i_cs_n,
    input  logic         i_ior_n,
    input  logic         i_iow_n,
    output access_kind_e o_kind,
    output logic         o_write_first,
    output logic         o_read_first,
    output logic         o_conflict_first
);

    logic         w_access;
    access_kind_e w_kind;
    access_kind_e r_prev_kind;

    // Classify the current bus sample; a deselected bus is always ACC_NONE
    always_comb begin
        w_kind   = ACC_NONE;
        w_access = i_program_condition & ~i_cs_n;
        if (w_access) begin
            case ({i_ior_n, i_iow_n})
                2'b10:   w_kind = ACC_WRITE;
                2'b01:   w_kind = ACC_READ;
                2'b00:   w_kind = ACC_CONFLICT;
                default: w_kind = ACC_NONE;
            endcase
        end
    end

    // Remember last cycle's classification; an episode starts when it changes
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev_kind <= ACC_NONE;
        end else begin
            r_prev_kind <= w_kind;
        end
    end

    assign o_kind           = w_kind;
    assign o_write_first    = (w_kind == ACC_WRITE)    && (r_prev_kind != ACC_WRITE);
    assign o_read_first     = (w_kind == ACC_READ)     && (r_prev_kind != ACC_READ);
    assign o_conflict_first = (w_kind == ACC_CONFLICT) && (r_prev_kind != ACC_CONFLICT);

endmodule

// File: rtl/dma_register_access_model.sv
// Behavioural model of the 8237-style DMA programming-interface decode.
// Watches the CPU bus and produces registered one-cycle load strobes,
// level read indications, the selected channel and a model of the
// byte-pointer flip-flop. All outputs lag the sampled bus by one cycle,
// and stay 0 for the first clock after RESET is released.
// Optional build macro MASK_DECODE_EN enables the request/mask strobes
// (0x9, 0xA, 0xE, 0xF); without it those four outputs are tied 0.
module dma_register_access_model
    import dma_model_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int NUM_CH = 4
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      programCondition,
    input  logic                      CS_N,
    input  logic                      IOR_N,
    input  logic                      IOW_N,
    input  logic                      A3,
    input  logic                      A2,
    input  logic                      A1,
    input  logic                      A0,
    output logic                      loadCommandReg,
    output logic                      loadRequestReg,
    output logic                      loadSingleMask,
    output logic                      loadModeReg,
    output logic                      clearInternalFF,
    output logic                      masterClear,
    output logic                      clearMaskReg,
    output logic                      loadAllMask,
    output logic                      loadBaseAddressReg,
    output logic                      loadBaseWordCountReg,
    output logic                      readCurrentAddressReg,
    output logic                      readCurrentWordCountReg,
    output logic                      readStatusReg,
    output logic                      readTemporaryReg,
    output logic                      loadIoDataBufferFromStatus,
    output logic [$clog2(NUM_CH)-1:0] channelSel,
    output logic                      upperByte,
    output logic                      protocolError
);

    localparam int CH_W = $clog2(NUM_CH);

    logic [ADDR_W-1:0] w_addr;
    access_kind_e      w_kind;
    logic              w_write_first;
    logic              w_read_first;
    logic              w_conflict_first;

    // Qualified events, suppressed during the first clock after reset
    logic w_wr_fire;
    logic w_rd_level;
    logic w_rd_fire;

    // Next-state values for every registered output
    logic            w_ld_cmd, w_ld_req, w_ld_smask, w_ld_mode;
    logic            w_clr_ff, w_mclr, w_clr_mask, w_ld_allmask;
    logic            w_ld_base, w_ld_wc;
    logic            w_rd_addr, w_rd_wc, w_rd_stat, w_rd_temp, w_ld_iobuf;
    logic            w_perr;
    logic            w_upper_nxt;
    logic [CH_W-1:0] w_chsel_nxt;

    // Registered state
    logic            r_armed;
    logic            r_ld_cmd, r_ld_req, r_ld_smask, r_ld_mode;
    logic            r_clr_ff, r_mclr, r_clr_mask, r_ld_allmask;
    logic            r_ld_base, r_ld_wc;
    logic            r_rd_addr, r_rd_wc, r_rd_stat, r_rd_temp, r_ld_iobuf;
    logic            r_perr;
    logic            r_upper;
    logic [CH_W-1:0] r_chsel;

    assign w_addr = {A3, A2, A1, A0};

    dma_access_edge u_edge (
        .i_clk               (CLK),
        .i_rst               (RESET),
        .i_program_condition (programCondition),
        .i_cs_n              (CS_N),
        .i_ior_n             (IOR_N),
        .i_iow_n             (IOW_N),
        .o_kind              (w_kind),
        .o_write_first       (w_write_first),
        .o_read_first        (w_read_first),
        .o_conflict_first    (w_conflict_first)
    );

    assign w_wr_fire  = r_armed & w_write_first;
    assign w_rd_level = r_armed & (w_kind == ACC_READ);
    assign w_rd_fire  = r_armed & w_read_first;
    assign w_perr     = r_armed & w_conflict_first;

    // Always-present command strobes
    assign w_ld_cmd  = w_wr_fire & (w_addr == ADDR_CMD);
    assign w_ld_mode = w_wr_fire & (w_addr == ADDR_MODE);
    assign w_clr_ff  = w_wr_fire & (w_addr == ADDR_CLRFF);
    assign w_mclr    = w_wr_fire & (w_addr == ADDR_MCLR);

`ifdef MASK_DECODE_EN
    assign w_ld_req     = w_wr_fire & (w_addr == ADDR_REQ);
    assign w_ld_smask   = w_wr_fire & (w_addr == ADDR_SMASK);
    assign w_clr_mask   = w_wr_fire & (w_addr == ADDR_CLRMASK);
    assign w_ld_allmask = w_wr_fire & (w_addr == ADDR_ALLMASK);
`else
    assign w_ld_req     = 1'b0;
    assign w_ld_smask   = 1'b0;
    assign w_clr_mask   = 1'b0;
    assign w_ld_allmask = 1'b0;
`endif

    // Channel registers: A3=0, A0 picks address (even) or word count (odd)
    assign w_ld_base  = w_wr_fire & ~w_addr[3] & ~w_addr[0];
    assign w_ld_wc    = w_wr_fire & ~w_addr[3] &  w_addr[0];

    // Read indications hold for the whole access; the buffer load only once
    assign w_rd_addr  = w_rd_level & ~w_addr[3] & ~w_addr[0];
    assign w_rd_wc    = w_rd_level & ~w_addr[3] &  w_addr[0];
    assign w_rd_stat  = w_rd_level & (w_addr == ADDR_STATUS);
    assign w_rd_temp  = w_rd_level & (w_addr == ADDR_TEMP);
    assign w_ld_iobuf = w_rd_fire  & (w_addr == ADDR_STATUS);

    // Byte-pointer flip-flop and channel select next state; clear beats toggle
    always_comb begin
        w_upper_nxt = r_upper;
        w_chsel_nxt = r_chsel;
        if (w_clr_ff || w_mclr) begin
            w_upper_nxt = 1'b0;
        end else if (w_ld_base || w_ld_wc || (w_rd_fire && !w_addr[3])) begin
            w_upper_nxt = ~r_upper;
        end
        if (r_armed && ((w_kind == ACC_WRITE) || (w_kind == ACC_READ))) begin
            w_chsel_nxt = {A2, A1};
        end
    end

    // Register every output; reset clears everything asynchronously
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_armed      <= 1'b0;
            r_ld_cmd     <= 1'b0;
            r_ld_req     <= 1'b0;
            r_ld_smask   <= 1'b0;
            r_ld_mode    <= 1'b0;
            r_clr_ff     <= 1'b0;
            r_mclr       <= 1'b0;
            r_clr_mask   <= 1'b0;
            r_ld_allmask <= 1'b0;
            r_ld_base    <= 1'b0;
            r_ld_wc      <= 1'b0;
            r_rd_addr    <= 1'b0;
            r_rd_wc      <= 1'b0;
            r_rd_stat    <= 1'b0;
            r_rd_temp    <= 1'b0;
            r_ld_iobuf   <= 1'b0;
            r_perr       <= 1'b0;
            r_upper      <= 1'b0;
            r_chsel      <= '0;
        end else begin
            r_armed      <= 1'b1;
            r_ld_cmd     <= w_ld_cmd;
            r_ld_req     <= w_ld_req;
            r_ld_smask   <= w_ld_smask;
            r_ld_mode    <= w_ld_mode;
            r_clr_ff     <= w_clr_ff;
            r_mclr       <= w_mclr;
            r_clr_mask   <= w_clr_mask;
            r_ld_allmask <= w_ld_allmask;
            r_ld_base    <= w_ld_base;
            r_ld_wc      <= w_ld_wc;
            r_rd_addr    <= w_rd_addr;
            r_rd_wc      <= w_rd_wc;
            r_rd_stat    <= w_rd_stat;
            r_rd_temp    <= w_rd_temp;
            r_ld_iobuf   <= w_ld_iobuf;
            r_perr       <= w_perr;
            r_upper      <= w_upper_nxt;
            r_chsel      <= w_chsel_nxt;
        end
    end

    assign loadCommandReg             = r_ld_cmd;
    assign loadRequestReg             = r_ld_req;
    assign loadSingleMask             = r_ld_smask;
    assign loadModeReg                = r_ld_mode;
    assign clearInternalFF            = r_clr_ff;
    assign masterClear                = r_mclr;
    assign clearMaskReg               = r_clr_mask;
    assign loadAllMask                = r_ld_allmask;
    assign loadBaseAddressReg         = r_ld_base;
    assign loadBaseWordCountReg       = r_ld_wc;
    assign readCurrentAddressReg      = r_rd_addr;
    assign readCurrentWordCountReg    = r_rd_wc;
    assign readStatusReg              = r_rd_stat;
    assign readTemporaryReg           = r_rd_temp;
    assign loadIoDataBufferFromStatus = r_ld_iobuf;
    assign channelSel                 = r_chsel;
    assign upperByte                  = r_upper;
    assign protocolError              = r_perr;

endmodule

// File: tb/tb_dma_register_access_model.sv
// Self-checking bench for dma_register_access_model. A driver applies bus
// cycles on the falling clock edge and pushes the expected output vector
// from an episode-level reference model; a monitor pops and compares after
// each rising edge. Honours MASK_DECODE_EN the same way as the design.
module tb_dma_register_access_model;

`ifdef MASK_DECODE_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic programCondition = 1'b0;
    logic CS_N = 1'b1;
    logic IOR_N = 1'b1;
    logic IOW_N = 1'b1;
    logic A3 = 1'b0, A2 = 1'b0, A1 = 1'b0, A0 = 1'b0;

    logic loadCommandReg, loadRequestReg, loadSingleMask, loadModeReg;
    logic clearInternalFF, masterClear, clearMaskReg, loadAllMask;
    logic loadBaseAddressReg, loadBaseWordCountReg;
    logic readCurrentAddressReg, readCurrentWordCountReg, readStatusReg, readTemporaryReg;
    logic loadIoDataBufferFromStatus, upperByte, protocolError;
    logic [1:0] channelSel;

    int checks = 0;
    int failures = 0;
    logic [18:0] exp_q[$];

    // Reference model state: what kind of episode the bus was in last cycle
    int         m_prev_kind = 0;   // 0 none, 1 write, 2 read, 3 conflict
    bit         m_armed = 1'b0;
    bit         m_upper = 1'b0;
    logic [1:0] m_chsel = 2'b00;

    dma_register_access_model dut (
        .CLK                        (CLK),
        .RESET                      (RESET),
        .programCondition           (programCondition),
        .CS_N                       (CS_N),
        .IOR_N                      (IOR_N),
        .IOW_N                      (IOW_N),
        .A3                         (A3),
        .A2                         (A2),
        .A1                         (A1),
        .A0                         (A0),
        .loadCommandReg             (loadCommandReg),
        .loadRequestReg             (loadRequestReg),
        .loadSingleMask             (loadSingleMask),
        .loadModeReg                (loadModeReg),
        .clearInternalFF            (clearInternalFF),
        .masterClear                (masterClear),
        .clearMaskReg               (clearMaskReg),
        .loadAllMask                (loadAllMask),
        .loadBaseAddressReg         (loadBaseAddressReg),
        .loadBaseWordCountReg       (loadBaseWordCountReg),
        .readCurrentAddressReg      (readCurrentAddressReg),
        .readCurrentWordCountReg    (readCurrentWordCountReg),
        .readStatusReg              (readStatusReg),
        .readTemporaryReg           (readTemporaryReg),
        .loadIoDataBufferFromStatus (loadIoDataBufferFromStatus),
        .channelSel                 (channelSel),
        .upperByte                  (upperByte),
        .protocolError              (protocolError)
    );

    wire [18:0] w_act = {loadCommandReg, loadRequestReg, loadSingleMask, loadModeReg,
                         clearInternalFF, masterClear, clearMaskReg, loadAllMask,
                         loadBaseAddressReg, loadBaseWordCountReg,
                         readCurrentAddressReg, readCurrentWordCountReg,
                         readStatusReg, readTemporaryReg, loadIoDataBufferFromStatus,
                         channelSel, upperByte, protocolError};

    // Clock generation
    always #5 CLK = ~CLK;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1, "watchdog expired");
    end

    // Reference: expected outputs after the rising edge that samples this bus cycle
    function automatic logic [18:0] model_step(input bit rst, input bit pc, input bit cs_n,
                                               input bit ior_n, input bit iow_n,
                                               input logic [3:0] addr);
        bit ld_cmd = 0, ld_req = 0, ld_smask = 0, ld_mode = 0;
        bit clr_ff = 0, mclr = 0, clr_mask = 0, ld_all = 0, ld_base = 0, ld_wc = 0;
        bit rd_addr = 0, rd_wc = 0, rd_stat = 0, rd_temp = 0, ld_iobuf = 0, perr = 0;
        int kind;
        bit new_ep;
        if (rst) begin
            m_prev_kind = 0;
            m_armed     = 0;
            m_upper     = 0;
            m_chsel     = 2'b00;
            return '0;
        end
        kind = 0;
        if (pc && !cs_n) begin
            if (!iow_n && ior_n)       kind = 1;
            else if (!ior_n && iow_n)  kind = 2;
            else if (!ior_n && !iow_n) kind = 3;
        end
        new_ep = (kind != m_prev_kind);
        if (m_armed) begin
            if (kind == 1 && new_ep) begin
                if (addr < 8) begin
                    if (addr % 2 == 0) ld_base = 1; else ld_wc = 1;
                end else begin
                    case (addr)
                        4'h8: ld_cmd   = 1;
                        4'h9: ld_req   = MASK_EN;
                        4'hA: ld_smask = MASK_EN;
                        4'hB: ld_mode  = 1;
                        4'hC: clr_ff   = 1;
                        4'hD: mclr     = 1;
                        4'hE: clr_mask = MASK_EN;
                        default: ld_all = MASK_EN;
                    endcase
                end
            end
            if (kind == 2) begin
                if (addr < 8) begin
                    if (addr % 2 == 0) rd_addr = 1; else rd_wc = 1;
                end
                if (addr == 4'h8) begin
                    rd_stat  = 1;
                    ld_iobuf = new_ep;
                end
                if (addr == 4'hD) rd_temp = 1;
            end
            if (kind == 1 || kind == 2) m_chsel = addr[2:1];
            if (clr_ff || mclr)
                m_upper = 0;
            else if (ld_base || ld_wc || (kind == 2 && new_ep && addr < 8))
                m_upper = !m_upper;
            perr = (kind == 3) && new_ep;
        end
        m_prev_kind = kind;
        m_armed     = 1;
        return {ld_cmd, ld_req, ld_smask, ld_mode, clr_ff, mclr, clr_mask, ld_all,
                ld_base, ld_wc, rd_addr, rd_wc, rd_stat, rd_temp, ld_iobuf,
                m_chsel, m_upper, perr};
    endfunction

    // Driver: apply one bus cycle on the falling edge and queue its expectation
    task automatic step(input bit rst, input bit pc, input bit cs_n,
                        input bit ior_n, input bit iow_n, input logic [3:0] addr);
        @(negedge CLK);
        RESET            = rst;
        programCondition = pc;
        CS_N             = cs_n;
        IOR_N            = ior_n;
        IOW_N            = iow_n;
        {A3, A2, A1, A0} = addr;
        exp_q.push_back(model_step(rst, pc, cs_n, ior_n, iow_n, addr));
        if (rst) begin
            // Reset must clear outputs before any clock edge arrives
            #1;
            checks++;
            if (w_act !== 19'h0) begin
                failures++;
                $display("FAIL async_reset: got=%h required=%h", w_act, 19'h0);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 1, 1, 1, 4'h0);
    endtask

    task automatic wr(input logic [3:0] addr, input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 1, 0, addr);
    endtask

    task automatic rd(input logic [3:0] addr, input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 1, addr);
    endtask

    // Monitor: compare the full output vector after each rising edge
    initial begin
        logic [18:0] e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (w_act !== e) begin
                    failures++;
                    $display("FAIL outputs t=%0t: got=%h required=%h", $time, w_act, e);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int hold;
        int pat;
        bit pc, cs_n, ior_n, iow_n, rst;
        logic [3:0] addr;

        for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 1, 4'h0);
        idle(3);

        // Command write held three cycles: one pulse only
        wr(4'h8, 3);
        idle(2);
        // Two base-address writes to channel 1, then clear the byte pointer
        wr(4'h2, 2); idle(1);
        wr(4'h2, 2); idle(1);
        wr(4'hC, 1); idle(2);
        // Status read for four cycles
        rd(4'h8, 4); idle(2);
        // Unqualified mode writes
        step(0, 1, 1, 1, 0, 4'hB); step(0, 1, 1, 1, 0, 4'hB);
        step(0, 0, 0, 1, 0, 4'hB); step(0, 0, 0, 1, 0, 4'hB);
        idle(1);
        // Both strobes low while qualified
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 4'h3);
        idle(2);
        // Mask-family writes
        wr(4'hF, 2); idle(1);
        wr(4'h9, 1); idle(1); wr(4'hA, 1); idle(1); wr(4'hE, 1); idle(1);
        // Word-count write toggles pointer, master clear resets it
        wr(4'h5, 1); idle(1); wr(4'hD, 1); idle(1);
        // Reads of current address / word count and temporary register
        rd(4'h0, 3); rd(4'h1, 2); idle(1); rd(4'h7, 2); idle(1); rd(4'hD, 2); rd(4'hA, 2); idle(1);
        // CS_N bounce mid-write needs a fresh edge to pulse again
        wr(4'h0, 2); step(0, 1, 1, 1, 0, 4'h0); wr(4'h0, 2); idle(1);
        // Reset asserted while a write is in flight, released with it still held
        wr(4'h4, 2);
        step(1, 1, 0, 1, 0, 4'h4); step(1, 1, 0, 1, 0, 4'h4);
        wr(4'h4, 2); idle(2);
        wr(4'h6, 1); idle(1);

        // Randomized bus traffic
        for (int n = 0; n < 300; n++) begin
            hold  = $urandom_range(1, 4);
            pc    = ($urandom_range(0, 7) != 0);
            cs_n  = ($urandom_range(0, 7) == 0);
            pat   = $urandom_range(0, 9);
            ior_n = !(pat >= 4 && pat <= 7);
            iow_n = !(pat <= 3 || pat == 7);
            addr  = 4'($urandom_range(0, 15));
            rst   = ($urandom_range(0, 63) == 0);
            for (int h = 0; h < hold; h++) step(rst, pc, cs_n, ior_n, iow_n, addr);
        end
        idle(2);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got=%0d pending required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
